// File: rtl/iir_df1_biquad_axis_pkg.sv
// Shared types, width constants and the saturating arithmetic shift for the DF1 biquad.
package iir_df1_biquad_axis_pkg;

    localparam int COEFF_W   = 16;
    localparam int INOUT_W   = 16;
    localparam int SCALE_F   = 14;
    localparam int ACC_GUARD = 3;
    localparam int PROD_W    = COEFF_W + INOUT_W;
    localparam int ACC_W     = PROD_W + ACC_GUARD;

    typedef logic signed [INOUT_W-1:0] sample_t;
    typedef logic signed [COEFF_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUM  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Arithmetic right shift (floor) followed by a clamp to a signed out_w-bit range.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] acc,
        input int                 shift,
        input int                 out_w
    );
        logic signed [63:0] sh;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        sh = acc >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (sh > hi) begin
            res = hi;
        end else if (sh < lo) begin
            res = lo;
        end else begin
            res = sh;
        end
        return res;
    endfunction

endpackage

// File: rtl/iir_df1_biquad_axis_sat_shift.sv
// Accumulator to output-sample conversion: floor shift by the coefficient scale, then clamp.
module biquad_sat_shift
    import iir_df1_biquad_axis_pkg::*;
#(
    parameter int acc_w = 35,
    parameter int out_w = 16,
    parameter int shift = 14
) (
    input  logic signed [acc_w-1:0] acc,
    output logic signed [out_w-1:0] y
);

    logic signed [63:0] wide_s;

    // Widen, shift and clamp; the clamped value always fits in out_w bits.
    always_comb begin
        wide_s = 64'sd0;
        wide_s = sat_shift(64'(acc), shift, out_w);
        y      = wide_s[out_w-1:0];
    end

endmodule

// File: rtl/iir_df1_biquad_axis.sv
// Fixed-coefficient Direct Form 1 biquad with AXI4-Stream input and output.
// One sample every three cycles; output backpressure never stalls the filter.
module iir_df1_biquad_axis
    import iir_df1_biquad_axis_pkg::*;
#(
    parameter int coeff_width  = COEFF_W,
    parameter int inout_width  = INOUT_W,
    parameter int scale_factor = SCALE_F,
    parameter int a1_int_coeff = -31880,
    parameter int a2_int_coeff = 15531,
    parameter int bo_int_coeff = 167,
    parameter int b1_int_coeff = -302,
    parameter int b2_int_coeff = 167
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_axis_tvalid,
    input  logic signed [inout_width-1:0] s_axis_tdata,
    output logic                          s_axis_tready,
    output logic                          m_axis_tvalid,
    output logic signed [inout_width-1:0] m_axis_tdata,
    input  logic                          m_axis_tready
);

    localparam int prod_w = coeff_width + inout_width;
    localparam int acc_w  = prod_w + ACC_GUARD;

    localparam logic signed [coeff_width-1:0] b0_c = coeff_width'(bo_int_coeff);
    localparam logic signed [coeff_width-1:0] b1_c = coeff_width'(b1_int_coeff);
    localparam logic signed [coeff_width-1:0] b2_c = coeff_width'(b2_int_coeff);
    localparam logic signed [coeff_width-1:0] a1_c = coeff_width'(a1_int_coeff);
    localparam logic signed [coeff_width-1:0] a2_c = coeff_width'(a2_int_coeff);

    state_t                        state_r;
    logic                          s_ready_r;
    logic signed [inout_width-1:0] x_in_r;
    logic signed [inout_width-1:0] x1_r;
    logic signed [inout_width-1:0] x2_r;
    logic signed [inout_width-1:0] y1_r;
    logic signed [inout_width-1:0] y2_r;
    logic signed [prod_w-1:0]      p_b0_r;
    logic signed [prod_w-1:0]      p_b1_r;
    logic signed [prod_w-1:0]      p_b2_r;
    logic signed [prod_w-1:0]      p_a1_r;
    logic signed [prod_w-1:0]      p_a2_r;
    logic signed [acc_w-1:0]       acc_s;
    logic signed [inout_width-1:0] y_new_s;
    logic signed [inout_width-1:0] result_r;
    logic                          pending_r;
    logic                          m_valid_r;
    logic signed [inout_width-1:0] m_data_r;
    logic                          out_free_s;

    // Sum of the registered products; the guard bits keep this exact.
    always_comb begin
        acc_s = acc_w'(p_b0_r) + acc_w'(p_b1_r) + acc_w'(p_b2_r)
              - acc_w'(p_a1_r) - acc_w'(p_a2_r);
    end

    biquad_sat_shift #(
        .acc_w (acc_w),
        .out_w (inout_width),
        .shift (scale_factor)
    ) u_sat_shift (
        .acc (acc_s),
        .y   (y_new_s)
    );

    // Accept/multiply/sum sequencer and filter history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            s_ready_r <= 1'b0;
            x_in_r    <= '0;
            x1_r      <= '0;
            x2_r      <= '0;
            y1_r      <= '0;
            y2_r      <= '0;
            p_b0_r    <= '0;
            p_b1_r    <= '0;
            p_b2_r    <= '0;
            p_a1_r    <= '0;
            p_a2_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (s_axis_tvalid && s_ready_r) begin
                        p_b0_r    <= prod_w'(b0_c) * prod_w'(s_axis_tdata);
                        p_b1_r    <= prod_w'(b1_c) * prod_w'(x1_r);
                        p_b2_r    <= prod_w'(b2_c) * prod_w'(x2_r);
                        p_a1_r    <= prod_w'(a1_c) * prod_w'(y1_r);
                        p_a2_r    <= prod_w'(a2_c) * prod_w'(y2_r);
                        x_in_r    <= s_axis_tdata;
                        s_ready_r <= 1'b0;
                        state_r   <= ST_SUM;
                    end else begin
                        s_ready_r <= 1'b1;
                    end
                end
                ST_SUM: begin
                    x2_r      <= x1_r;
                    x1_r      <= x_in_r;
                    y2_r      <= y1_r;
                    y1_r      <= y_new_s;
                    s_ready_r <= 1'b0;
                    state_r   <= ST_HOLD;
                end
                ST_HOLD: begin
                    s_ready_r <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    s_ready_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_free_s = !m_valid_r || m_axis_tready;

    // Single-slot pending result and the output register; newest result wins during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r  <= '0;
            pending_r <= 1'b0;
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
        end else begin
            if (state_r == ST_SUM) begin
                result_r  <= y_new_s;
                pending_r <= 1'b1;
            end else if (out_free_s && pending_r) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end

            if (out_free_s) begin
                if (pending_r) begin
                    m_data_r  <= result_r;
                    m_valid_r <= 1'b1;
                end else begin
                    m_valid_r <= 1'b0;
                end
            end else begin
                m_valid_r <= m_valid_r;
            end
        end
    end

    assign s_axis_tready = s_ready_r;
    assign m_axis_tvalid = m_valid_r;
    assign m_axis_tdata  = m_data_r;

endmodule

// File: tb/tb_iir_df1_biquad_axis.sv
// Directed bench for iir_df1_biquad_axis: impulse, reset, DC step, handshake, backpressure, saturation.
module tb_iir_df1_biquad_axis;
    import iir_df1_biquad_axis_pkg::*;

    localparam longint B0 = 167;
    localparam longint B1 = -302;
    localparam longint B2 = 167;
    localparam longint A1 = -31880;
    localparam longint A2 = 15531;

    logic    clk;
    logic    rst;
    logic    s_valid;
    sample_t s_data;
    logic    s_ready;
    logic    m_valid;
    sample_t m_data;
    logic    m_ready;

    logic    sv2;
    sample_t sd2;
    logic    sr2;
    logic    mv2;
    sample_t md2;
    logic    mr2;

    int n_checks;
    int n_pass;

    longint mx1, mx2, my1, my2;

    iir_df1_biquad_axis u_dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_valid),
        .s_axis_tdata  (s_data),
        .s_axis_tready (s_ready),
        .m_axis_tvalid (m_valid),
        .m_axis_tdata  (m_data),
        .m_axis_tready (m_ready)
    );

    iir_df1_biquad_axis #(
        .bo_int_coeff (32767),
        .b1_int_coeff (0),
        .b2_int_coeff (0),
        .a1_int_coeff (0),
        .a2_int_coeff (0)
    ) u_sat_dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (sv2),
        .s_axis_tdata  (sd2),
        .s_axis_tready (sr2),
        .m_axis_tvalid (mv2),
        .m_axis_tdata  (md2),
        .m_axis_tready (mr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
    endtask

    // Reference difference equation with floor shift and clamp.
    task automatic model_step(input longint x, output longint y);
        longint acc;
        acc = B0 * x + B1 * mx1 + B2 * mx2 - A1 * my1 - A2 * my2;
        y = acc >>> 14;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        mx2 = mx1; mx1 = x;
        my2 = my1; my1 = y;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send(input longint x);
        int w;
        w = 0;
        while (!s_ready && w < 20) begin
            tick();
            w++;
        end
        if (!s_ready) check_val("ready_timeout", longint'(s_ready), 1);
        s_valid = 1'b1;
        s_data  = 16'(x);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic push_expect(input longint x, input longint exp, input string tag);
        send(x);
        tick();
        check_val("early_valid", longint'(m_valid), 0);
        tick();
        check_val("valid_lat2", longint'(m_valid), 1);
        check_val(tag, longint'(m_data), exp);
    endtask

    task automatic run_impulse(input string tag);
        longint y;
        model_step(16384, y);
        push_expect(16384, 167, tag);
        model_step(0, y);
        push_expect(0, 22, tag);
        model_step(0, y);
        push_expect(0, 51, tag);
    endtask

    task automatic sat_push(input longint x, input longint exp);
        int w;
        w = 0;
        while (!sr2 && w < 20) begin
            tick();
            w++;
        end
        if (!sr2) check_val("sat_ready_timeout", longint'(sr2), 1);
        sv2 = 1'b1;
        sd2 = 16'(x);
        tick();
        sv2 = 1'b0;
        tick();
        tick();
        check_val("sat_valid", longint'(mv2), 1);
        check_val("sat_data", longint'(md2), exp);
    endtask

    initial begin
        longint y;
        longint held;
        longint hs_exp[12];
        longint hs_in[12];
        longint bp_in[28];
        int     idx, n_out, last_acc, cyc;
        logic   acc_now;

        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        sv2 = 1'b0; sd2 = '0; mr2 = 1'b1;
        model_reset();

        repeat (3) tick();
        check_val("rst_s_ready", longint'(s_ready), 0);
        check_val("rst_m_valid", longint'(m_valid), 0);
        check_val("rst_m_data", longint'(m_data), 0);
        rst = 1'b0;
        tick();
        check_val("idle_s_ready", longint'(s_ready), 1);

        sat_push(32767, 32767);
        sat_push(-32768, -32768);

        run_impulse("impulse");

        // Reset between samples discards history.
        send(5000);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_val("midrst_s_ready", longint'(s_ready), 0);
        check_val("midrst_m_valid", longint'(m_valid), 0);
        check_val("midrst_m_data", longint'(m_data), 0);
        rst = 1'b0;
        model_reset();
        run_impulse("impulse_after_rst");

        do_reset(2);
        for (int i = 0; i < 1000; i++) begin
            model_step(1000, y);
            push_expect(1000, y, "dc_step");
        end
        check_val("dc_no_sat", longint'(m_data < 16'sd32767 && m_data > -16'sd32768), 1);

        // Back-to-back s_axis_tvalid: three-cycle accept spacing, no loss or duplication.
        do_reset(2);
        for (int i = 0; i < 12; i++) begin
            hs_in[i] = (i % 2 == 0) ? longint'(i * 2500) : longint'(-i * 1700);
            model_step(hs_in[i], hs_exp[i]);
        end
        idx = 0; n_out = 0; last_acc = -1;
        s_valid = 1'b1;
        s_data  = 16'(hs_in[0]);
        for (cyc = 0; cyc < 60 && n_out < 12; cyc++) begin
            acc_now = s_valid && s_ready;
            tick();
            if (m_valid) begin
                check_val("hs_data", longint'(m_data), hs_exp[n_out]);
                n_out++;
            end
            if (acc_now) begin
                if (last_acc >= 0) check_val("hs_accept_gap", longint'(cyc - last_acc), 3);
                last_acc = cyc;
                idx++;
                if (idx < 12) begin
                    s_data = 16'(hs_in[idx]);
                end else begin
                    s_valid = 1'b0;
                end
            end
        end
        s_valid = 1'b0;
        check_val("hs_accepted", longint'(idx), 12);
        check_val("hs_outputs", longint'(n_out), 12);

        // Output stall for 20 samples; filter keeps running, newest result kept.
        do_reset(2);
        for (int i = 0; i < 28; i++) bp_in[i] = longint'((i * 3917) % 20000) - 10000;
        for (int i = 0; i < 5; i++) begin
            model_step(bp_in[i], y);
            push_expect(bp_in[i], y, "bp_pre");
        end
        held = y;
        m_ready = 1'b0;
        for (int i = 5; i < 25; i++) begin
            model_step(bp_in[i], y);
            send(bp_in[i]);
            check_val("bp_hold_valid", longint'(m_valid), 1);
            check_val("bp_hold_data", longint'(m_data), held);
            tick();
            check_val("bp_hold_data", longint'(m_data), held);
            tick();
            check_val("bp_hold_valid", longint'(m_valid), 1);
            check_val("bp_hold_data", longint'(m_data), held);
        end
        m_ready = 1'b1;
        tick();
        check_val("bp_newest_valid", longint'(m_valid), 1);
        check_val("bp_newest_data", longint'(m_data), y);
        tick();
        check_val("bp_drained", longint'(m_valid), 0);
        for (int i = 25; i < 28; i++) begin
            model_step(bp_in[i], y);
            push_expect(bp_in[i], y, "bp_post");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
